// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction fetch stage: next-PC select codes,
// fetch FSM states, the NOP word and the default reset PC.
package fetch_pkg;

  localparam logic [1:0]  PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0]  PCSRC_TARGET = 2'b01;
  localparam logic [1:0]  PCSRC_ALU    = 2'b10;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC     = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry PC + instruction holding buffer used when decode stalls on the
// cycle a fetch response arrives. Clear has priority over load.
module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            full_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            full_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= XLEN'(NOP_INSTR);
    end else if (clear_i) begin
      full_q  <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign full_o  = full_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register, redirect handling and a skid
// buffer. Optional macro FETCH_MISALIGN_TRAP_EN adds the MisalignD output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            StallD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            MisalignD,
`endif
  output logic            funct7b5
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q, pcd_d;
  logic [XLEN-1:0] pcp4_q, pcp4_d;
  logic            valid_q, valid_d;

  logic            skid_load, skid_clear, skid_full;
  logic [XLEN-1:0] skid_pc, skid_instr;

  logic            src_redir, redirect, fetch_en;
  logic [XLEN-1:0] target_raw, target, pc_plus4;

  always_comb begin
    src_redir  = 1'b0;
    target_raw = PCTarget;
    case (PCSrc)
      PCSRC_TARGET: begin src_redir = 1'b1; target_raw = PCTarget;  end
      PCSRC_ALU:    begin src_redir = 1'b1; target_raw = ALUResult; end
      PCSRC_PLUS4:  src_redir = 1'b0;
      default:      src_redir = 1'b0;  // reserved code behaves as PC+4
    endcase
  end

  assign redirect = valid_q & src_redir;
  assign target   = target_raw & {{(XLEN-2){1'b1}}, 2'b00};
  assign pc_plus4 = pc_q + XLEN'(4);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d, halt_q, halt_d, target_bad;
  assign target_bad = |target_raw[1:0];
  assign fetch_en   = ~halt_q;
  assign MisalignD  = misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
      halt_q     <= halt_d;
    end
  end
`else
  assign fetch_en = 1'b1;
`endif

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk     (clk),
    .rst     (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .full_o  (skid_full),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    pcp4_d       = pcp4_q;
    valid_d      = valid_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
    halt_d       = halt_q;
`endif

    case (state_q)
      IDLE: state_d = REQ;

      REQ: begin
        imem_req = fetch_en;
        if (redirect) begin
          // an unanswered request must still be drained before retargeting
          if (fetch_en && !imem_ack) begin
            state_d      = DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (fetch_en && imem_ack) begin
          pc_d = pc_plus4;
          if (StallD) begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end else begin
            instr_d = imem_rdata;
            pcd_d   = pc_q;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!StallD) begin
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect) begin
          state_d = REQ;
        end else if (!StallD && skid_full) begin
          instr_d    = skid_instr;
          pcd_d      = skid_pc;
          pcp4_d     = skid_pc + XLEN'(4);
          valid_d    = 1'b1;
          skid_clear = 1'b1;
          state_d    = REQ;
        end
      end

      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ack) state_d = REQ;
      end

      default: state_d = IDLE;
    endcase

    // redirect overrides any IF/ID update or skid capture chosen above
    if (redirect) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      pc_d       = target;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = target_bad;
      halt_d     = target_bad;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      instr_q      <= XLEN'(NOP_INSTR);
      pcd_q        <= '0;
      pcp4_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pcp4_q       <= pcp4_d;
      valid_q      <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pcd_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
  assign op       = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7b5 = instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/stall/redirect/reset scenarios, then
// randomized traffic checked against an instruction-stream reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget, ALUResult;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .ALUResult(ALUResult), .StallD(StallD), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .op(op), .funct3(funct3), .funct7b5(funct7b5)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned retired = 0;

  // model state: PC of the next instruction decode must see, plus bookkeeping
  logic [31:0] exp_pc;
  bit          pend;
  logic [31:0] pend_addr;
  bit          hold_prev;
  logic [31:0] hold_pcd;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit stall, input logic [1:0] src, input logic [31:0] tgt,
                       input logic [31:0] alu, input bit ack_ok);
    StallD    = stall;
    PCSrc     = src;
    PCTarget  = tgt;
    ALUResult = alu;
    if (imem_req && ack_ok) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  task automatic monitor();
    bit          redir, ret;
    logic [31:0] w;
    if (pend) begin
      check_eq("req_held", imem_req, 1);
      check_eq("addr_held", imem_addr, pend_addr);
    end
    if (imem_req) check_eq("addr_align", {30'd0, imem_addr[1:0]}, 0);
    if (hold_prev) begin
      check_eq("hold_valid", ValidD, 1);
      check_eq("hold_pcd", PCD, hold_pcd);
    end
    redir = ValidD && (PCSrc == 2'b01 || PCSrc == 2'b10);
    ret   = ValidD && (redir || !StallD);
    if (ret) begin
      w = mem_word(exp_pc);
      check_eq("seq_pcd", PCD, exp_pc);
      check_eq("seq_instr", InstrD, w);
      check_eq("seq_pcplus4", PCPlus4D, exp_pc + 32'd4);
      check_eq("seq_fields", {op, funct3, funct7b5}, {w[6:0], w[14:12], w[30]});
      if (redir) exp_pc = ((PCSrc == 2'b01) ? PCTarget : ALUResult) & 32'hFFFF_FFFC;
      else       exp_pc = exp_pc + 32'd4;
      retired++;
    end
    hold_prev = ValidD && !ret;
    hold_pcd  = PCD;
    pend      = imem_req && !imem_ack;
    pend_addr = imem_addr;
  endtask

  task automatic step();
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, imem_req, 0);
    check_eq({tag, "_valid"}, ValidD, 0);
    check_eq({tag, "_instr"}, InstrD, NOP);
    check_eq({tag, "_pcd"}, PCD, 0);
    check_eq({tag, "_pcplus4"}, PCPlus4D, 0);
    check_eq({tag, "_op"}, {25'd0, op}, 32'h13);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 2'b00, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset     = 1'b0;
    exp_pc    = RST_PC;
    pend      = 0;
    hold_prev = 0;
  endtask

  initial begin
    reset = 1'b1; StallD = 0; PCSrc = 0; PCTarget = 0; ALUResult = 0;
    imem_ack = 0; imem_rdata = 0;
    apply_reset();

    // boot latency with ack every cycle
    check_eq("boot_req", imem_req, 0);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("first_req", imem_req, 1);
    check_eq("first_addr", imem_addr, RST_PC);
    check_eq("n1_valid", ValidD, 0);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("n2_addr", imem_addr, 32'h4);
    check_eq("n2_valid", ValidD, 1);
    check_eq("n2_pcd", PCD, 32'h0);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("n3_addr", imem_addr, 32'h8);

    // stall for three cycles across the ack of PC=8
    drive(1, 2'b00, 0, 0, 1); step();
    for (int i = 0; i < 2; i++) begin
      check_eq("hold_req", imem_req, 0);
      check_eq("hold_instr", InstrD, mem_word(32'h4));
      drive(1, 2'b00, 0, 0, 1); step();
    end
    check_eq("hold_req", imem_req, 0);
    check_eq("hold_instr", InstrD, mem_word(32'h4));
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("unstall_instr", InstrD, mem_word(32'h8));
    check_eq("unstall_pcd", PCD, 32'h8);
    check_eq("unstall_addr", imem_addr, 32'hC);

    // branch redirect with same-cycle ack
    drive(0, 2'b01, 32'h100, 0, 1); step();
    check_eq("br_valid", ValidD, 0);
    check_eq("br_addr", imem_addr, 32'h100);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("br_pcd", PCD, 32'h100);

    // JALR redirect to misaligned 0x203 while request is outstanding
    drive(0, 2'b10, 0, 32'h203, 0); step();
    check_eq("drain_valid", ValidD, 0);
    check_eq("drain_addr", imem_addr, 32'h104);
    drive(0, 2'b00, 0, 0, 0); step();
    check_eq("drain_addr2", imem_addr, 32'h104);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("drain_discard", ValidD, 0);
    check_eq("jalr_addr", imem_addr, 32'h200);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("jalr_pcd", PCD, 32'h200);

    // wrap at top of address space
    drive(0, 2'b01, 32'hFFFF_FFFC, 0, 1); step();
    check_eq("wrap_fetch", imem_addr, 32'hFFFF_FFFC);
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("wrap_pcplus4", PCPlus4D, 32'h0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // asynchronous reset with a request pending
    check_eq("pre_rst_req", imem_req, 1);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    apply_reset();
    drive(0, 2'b00, 0, 0, 1); step();
    check_eq("restart_req", imem_req, 1);
    check_eq("restart_addr", imem_addr, RST_PC);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int unsigned r;
      logic [1:0]  src;
      r   = $urandom_range(0, 15);
      src = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      drive($urandom_range(0, 3) == 0, src, $urandom, $urandom, $urandom_range(0, 2) != 0);
      step();
    end
    check_eq("progress", retired > 300, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter XLEN, default 32, address/instruction width.
REQ-003 clk  input  1  single clock, all state rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PCSrc  input  2  next-PC select from controller: 00 PC+4, 01 PCTarget, 10 ALUResult, 11 reserved (treated as 00).
REQ-006 PCTarget  input  XLEN  branch/JAL target.
REQ-007 ALUResult  input  XLEN  JALR target.
REQ-008 StallD  input  1  decode cannot accept a new instruction this cycle.
REQ-009 imem_req  output  1  instruction memory request valid.
REQ-010 imem_addr  output  XLEN  request address, word aligned.
REQ-011 imem_ack  input  1  response valid; imem_rdata is sampled in the same cycle.
REQ-012 imem_rdata  input  XLEN  fetched instruction.
REQ-013 InstrD, PCD, PCPlus4D  output  XLEN each  IF/ID register contents.
REQ-014 ValidD  output  1  IF/ID register holds a live instruction.
REQ-015 op[6:0], funct3[2:0], funct7b5  output  fields InstrD[6:0], [14:12] and [30] respectively, for the controller.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, HOLD, DRAIN.
REQ-017 IDLE: entered on reset; imem_req=0; goes to REQ on the next clock.
REQ-018 REQ: imem_req=1 and imem_addr=PC, both held stable until imem_ack.
REQ-019 REQ with ack and no StallD: InstrD<=rdata, PCD<=PC, PCPlus4D<=PC+4, ValidD<=1, PC<=PC+4, stay in REQ.
REQ-020 REQ with ack and StallD=1: rdata and PC are captured into the skid buffer, IF/ID is unchanged, state goes to HOLD.
REQ-021 HOLD: imem_req=0; when StallD=0, skid contents move to IF/ID (ValidD=1) and state returns to REQ.
REQ-022 StallD=1 with no buffered data: IF/ID and ValidD hold their values.
REQ-023 Redirect condition: ValidD=1 and PCSrc is 01 or 10; the next PC is PCTarget or ALUResult, with bits [1:0] forced to 0.
REQ-024 On redirect, the next clock clears ValidD, discards skid contents, and sets PC to the target.
REQ-025 Redirect in REQ without ack: state goes to DRAIN; address/req held until ack; that response is discarded; then REQ at the target.
REQ-026 Redirect with ack in the same cycle: the response is discarded; the next cycle is REQ at the target.
REQ-027 Redirect has priority over StallD.
REQ-028 PC arithmetic is modulo 2^XLEN; PC+4 wraps 32'hFFFF_FFFC->0.
REQ-029 Latency: reset release -> first imem_req after 1 cycle; ack cycle -> ValidD=1 on the next edge.

Reset
REQ-030 Asynchronous reset SHALL set PC=RESET_PC, state=IDLE, ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, skid empty, imem_req=0.
REQ-031 Reset mid-transaction abandons any pending ack; responses after reset release are only accepted in REQ.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN defined: a redirect target with bits [1:0]!=0 SHALL raise output MisalignD (1 bit) for one cycle with ValidD=0 and no fetch until the next redirect. Undefined: MisalignD is absent and the low bits are silently cleared.

Structure
REQ-033 A shared package holds the PCSrc encodings (PCSRC_PLUS4/TARGET/ALU), the FSM state enum, the NOP constant and RESET_PC.
REQ-034 One sub-module, fetch_skid_buf (a one-entry PC+instruction buffer with a full flag).

Verification
REQ-035 Reset release, ack every cycle -> addresses 0,4,8; ValidD rises 2 cycles after release; PCPlus4D=PCD+4.
REQ-036 StallD high 3 cycles during ack of PC=8 -> HOLD, imem_req=0, InstrD steady; after release InstrD=word@8, no skip or duplicate.
REQ-037 PCSrc=01, PCTarget=0x100 with ValidD=1 -> ValidD=0 next cycle, next imem_addr=0x100.
REQ-038 PCSrc=10, ALUResult=0x203, ack delayed 2 cycles -> DRAIN discards the stale word; fetch at 0x200 (macro off), or MisalignD pulse (macro on).
REQ-039 Reset asserted while imem_req=1 -> outputs at reset values immediately; restart at RESET_PC.
REQ-040 PC=0xFFFF_FFFC ack -> next imem_addr=0x0.
